imem_arb: RTL and testbench
===========================

# imem_arb

Two-requester arbiter that shares the single combinational read port of the instruction memory between the core fetch path (requester 0) and the debug/loader path (requester 1). It issues one word-aligned read per cycle, selects the winner round-robin with an optional debug lock, registers the read data and returns it with a one-cycle latency. It also flags out-of-range addresses. It sits between the fetch stage / debug port and the instruction memory.

## Interface
- `DEPTH_WORDS`, default 64: number of 32-bit words in the instruction memory; word index range 0..DEPTH_WORDS-1.
- `clk`, input, 1: sole clock; all state updates on its rising edge.
- `reset_n`, input, 1: reset, asynchronous assert, active-low.
- `f_req`, input, 1: fetch requester has a valid request.
- `f_addr`, input, 32: fetch byte address.
- `f_gnt`, output, 1: fetch request accepted this cycle.
- `f_rvalid`, output, 1: `f_rdata`/`f_err` valid.
- `f_rdata`, output, 32: fetch read data.
- `f_err`, output, 1: fetch address out of range.
- `d_req`, `d_addr`, `d_gnt`, `d_rvalid`, `d_rdata`, `d_err`: the same set for the debug requester.
- `d_lock`, input, 1: while high and debug owns the port, debug keeps priority.
- `mem_a`, output, 32: address to imem; low 2 bits forced to 0.
- `mem_rd`, input, 32: combinational read data from imem.

## Operation
- Handshake: a requester raises `req` with a stable `addr` and holds both until it sees `gnt`. A transfer occurs in any cycle where `req && gnt`. `gnt` is combinational from the `req` inputs and the arbiter state. At most one `gnt` is high per cycle.
- Arbitration state `last` (1 bit) records the last granted requester.
  - Only one `req` high: that requester is granted.
  - Both high: the requester not equal to `last` wins.
  - Lock override: if `d_lock && last==1 && d_req`, debug wins regardless.
- `mem_a` = the winner's `addr` with `[1:0]` zeroed. With no winner, `mem_a` = 0.
- Range check uses word index `addr[31:2]`. An index >= DEPTH_WORDS is an error:
  - the response carries `err`=1 and `rdata`=0;
  - the transfer still completes and still updates `last`.
- Response register: on a transfer, capture `{owner, err, data}` from `mem_rd`. Next cycle, raise the owner's `rvalid` for exactly one cycle.
- No backpressure on responses; requesters must accept `rvalid` data.
- Back-to-back grants are allowed every cycle; responses pipeline one behind.
- Unaligned addresses (`addr[1:0]` != 0) are silently aligned.

## Timing
- Reset (`reset_n` low, asynchronous):
  - `last`=1, so fetch wins the first contended cycle;
  - all `rvalid`=0, all `err`=0, all `rdata`=0.
  - `gnt`/`mem_a` follow the combinational rules; `gnt` is forced to 0 while `reset_n` is low.
- Latency: request accepted in cycle N produces `rvalid` in cycle N+1 with the data of `mem_rd` sampled at the end of cycle N.
- Throughput: 1 transfer/cycle. Under continuous contention without lock, grants alternate F, D, F, D…
- Reset asserted mid-stream: the pending response is discarded and no `rvalid` appears after release.
- `req` deasserted before `gnt`: not a protocol violation; the request is withdrawn and no response is produced.

## Structure
- Package `imem_pkg`:
  - `REQ_F`=1'b0, `REQ_D`=1'b1 owner encoding;
  - `WORD_W`=32;
  - a packed struct `imem_rsp_t {owner, err, data}` for the response register.
- One natural sub-module `rr_arb2`: a 2-way round-robin grant with lock. Inputs `req[1:0]`, `lock`, `last`; output one-hot `gnt[1:0]`. Purely combinational; `last` is held in `imem_arb`.
- Memory behaviour in the bench: a 64-word model preloaded with word i = 0xA5000000 + i.

## Test plan
- **Single fetch:** `f_req`=1, `f_addr`=0x10 -> `f_gnt`=1 same cycle, `mem_a`=0x10; next cycle `f_rvalid`=1, `f_rdata`=0xA5000004, `d_rvalid`=0.
- **Contention after reset:** both `req` held, addrs 0x0/0x4 -> grants F, D, F, D. Responses 0xA5000000 on `f_rdata`, then 0xA5000001 on `d_rdata`, alternating.
- **Debug lock:**
  - `d_lock`=1, both requesting, debug granted once -> debug granted every following cycle while lock is held.
  - Drop `d_lock` -> next contended grant goes to fetch.
- **Out of range:** `d_addr`=0x100 (index 64) -> `d_gnt`=1; next cycle `d_rvalid`=1, `d_err`=1, `d_rdata`=0.
- **Unaligned:** `f_addr`=0x13 -> `mem_a`=0x10, `f_rdata`=0xA5000004.
- **Reset mid-stream:** `reset_n` pulsed low in the cycle after a grant -> no `rvalid` after release. The next contended grant goes to fetch.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction-memory arbiter.
package imem_pkg;

   localparam int   WORD_W = 32;
   localparam logic REQ_F  = 1'b0;
   localparam logic REQ_D  = 1'b1;

   // One registered read response, tagged with the requester it belongs to.
   typedef struct packed {
      logic              owner;
      logic              err;
      logic [WORD_W-1:0] data;
   } imem_rsp_t;

   // Word-align a byte address.
   function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
      return {addr[WORD_W-1:2], 2'b00};
   endfunction

   // True when the word index of addr falls outside a memory of depth words.
   function automatic logic word_oob(input logic [WORD_W-1:0] addr, input int depth);
      logic [WORD_W-1:0] idx;
      idx = {2'b00, addr[WORD_W-1:2]};
      return idx >= WORD_W'(depth);
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant with a sticky lock for requester 1.
module rr_arb2
   import imem_pkg::*;
(
   input  logic [1:0] req,
   input  logic       lock,
   input  logic       last,
   output logic [1:0] gnt
);

   // Lock keeps debug on the port; otherwise the side not served last wins a tie.
   always_comb begin
      gnt = 2'b00;
      if (lock && (last == REQ_D) && req[REQ_D])
         gnt = 2'b10;
      else if (req == 2'b11)
         gnt = (last == REQ_D) ? 2'b01 : 2'b10;
      else
         gnt = req;
   end

endmodule

// File: rtl/imem_arb.sv
// Shares the combinational imem read port between fetch and debug,
// returning registered read data one cycle after each grant.
module imem_arb
   import imem_pkg::*;
#(
   parameter int DEPTH_WORDS = 64
)
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              f_req,
   input  logic [WORD_W-1:0] f_addr,
   output logic              f_gnt,
   output logic              f_rvalid,
   output logic [WORD_W-1:0] f_rdata,
   output logic              f_err,
   input  logic              d_req,
   input  logic [WORD_W-1:0] d_addr,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [WORD_W-1:0] d_rdata,
   output logic              d_err,
   input  logic              d_lock,
   output logic [WORD_W-1:0] mem_a,
   input  logic [WORD_W-1:0] mem_rd
);

   logic [1:0]        arb_gnt;
   logic [1:0]        gnt;
   logic              last;
   logic              xfer;
   logic [WORD_W-1:0] win_addr;
   logic              win_err;
   logic              rsp_vld;
   imem_rsp_t         rsp;

   rr_arb2 u_arb (
      .req  ({d_req, f_req}),
      .lock (d_lock),
      .last (last),
      .gnt  (arb_gnt)
   );

   // No grant can escape while reset is held, even though the arbiter is combinational.
   assign gnt   = reset_n ? arb_gnt : 2'b00;
   assign f_gnt = gnt[REQ_F];
   assign d_gnt = gnt[REQ_D];
   assign xfer  = |gnt;

   assign win_addr = gnt[REQ_D] ? d_addr : f_addr;
   assign mem_a    = xfer ? word_align(win_addr) : '0;
   assign win_err  = word_oob(win_addr, DEPTH_WORDS);

   // Track the last served requester; reset favours fetch on the first tie.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         last <= REQ_D;
      else if (xfer)
         last <= gnt[REQ_D];
   end

   // Capture the read response of each transfer; it lives for exactly one cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rsp_vld <= 1'b0;
         rsp     <= '0;
      end else begin
         rsp_vld <= xfer;
         if (xfer) begin
            rsp.owner <= gnt[REQ_D];
            rsp.err   <= win_err;
            rsp.data  <= win_err ? '0 : mem_rd;
         end
      end
   end

   // Route the single response register to its owner; idle side reads zero.
   assign f_rvalid = rsp_vld && (rsp.owner == REQ_F);
   assign d_rvalid = rsp_vld && (rsp.owner == REQ_D);
   assign f_rdata  = f_rvalid ? rsp.data : '0;
   assign d_rdata  = d_rvalid ? rsp.data : '0;
   assign f_err    = f_rvalid && rsp.err;
   assign d_err    = d_rvalid && rsp.err;

endmodule

// File: tb/tb_imem_arb.sv
// Bench for imem_arb: directed vector table, reset corner cases and a
// randomized run checked against a rule-level reference model.
module tb_imem_arb;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        f_req, d_req, d_lock;
   logic [31:0] f_addr, d_addr;
   logic        f_gnt, f_rvalid, f_err, d_gnt, d_rvalid, d_err;
   logic [31:0] f_rdata, d_rdata, mem_a, mem_rd;

   int tests = 0;
   int fails = 0;

   imem_arb #(.DEPTH_WORDS(64)) dut (
      .clk(clk), .reset_n(reset_n),
      .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
      .f_rdata(f_rdata), .f_err(f_err),
      .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
      .d_rdata(d_rdata), .d_err(d_err),
      .d_lock(d_lock), .mem_a(mem_a), .mem_rd(mem_rd)
   );

   always #5 clk = ~clk;

   // Memory model: 64 words, word i = 0xA5000000 + i; beyond that returns junk.
   always_comb begin
      if (mem_a[31:2] < 30'd64) mem_rd = 32'hA500_0000 + {2'b00, mem_a[31:2]};
      else                      mem_rd = 32'hDEAD_0000 | {16'h0, mem_a[17:2]};
   end

   // ---- reference model state ----
   logic        m_last;          // 1 = debug was served last
   logic        m_pv, m_po, m_pe;
   logic [31:0] m_pd;
   logic        e_fg, e_dg;
   logic [31:0] e_ma;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      m_last = 1'b1; m_pv = 1'b0; m_po = 1'b0; m_pe = 1'b0; m_pd = '0;
   endtask

   // Drive one cycle's inputs and predict the combinational outputs from the rules.
   task automatic apply(input logic fr, input logic [31:0] fa, input logic dr,
                        input logic [31:0] da, input logic lk);
      logic win_d;
      f_req = fr; f_addr = fa; d_req = dr; d_addr = da; d_lock = lk;
      e_fg = 1'b0; e_dg = 1'b0; e_ma = '0;
      if (fr || dr) begin
         if (!dr)                 win_d = 1'b0;
         else if (!fr)            win_d = 1'b1;
         else if (lk && m_last)   win_d = 1'b1;
         else                     win_d = !m_last;
         e_fg = !win_d; e_dg = win_d;
         e_ma = (win_d ? da : fa) & ~32'd3;
      end
   endtask

   // Clock edge: the model accepts the predicted transfer.
   task automatic advance();
      int unsigned idx;
      @(posedge clk);
      if (e_fg || e_dg) begin
         idx    = e_ma >> 2;
         m_pv   = 1'b1;
         m_po   = e_dg;
         m_pe   = (idx >= 64);
         m_pd   = m_pe ? 32'h0 : 32'hA500_0000 + idx;
         m_last = e_dg;
      end else begin
         m_pv = 1'b0;
      end
      #1;
   endtask

   task automatic chk_model(input string tag);
      chk({tag, " f_gnt"},    {31'h0, f_gnt}, {31'h0, e_fg});
      chk({tag, " d_gnt"},    {31'h0, d_gnt}, {31'h0, e_dg});
      chk({tag, " mem_a"},    mem_a, e_ma);
      chk({tag, " f_rvalid"}, {31'h0, f_rvalid}, {31'h0, m_pv && !m_po});
      chk({tag, " d_rvalid"}, {31'h0, d_rvalid}, {31'h0, m_pv && m_po});
      if (m_pv && !m_po) begin
         chk({tag, " f_rdata"}, f_rdata, m_pd);
         chk({tag, " f_err"},   {31'h0, f_err}, {31'h0, m_pe});
      end
      if (m_pv && m_po) begin
         chk({tag, " d_rdata"}, d_rdata, m_pd);
         chk({tag, " d_err"},   {31'h0, d_err}, {31'h0, m_pe});
      end
   endtask

   typedef struct {
      logic        fr;  logic [31:0] fa;
      logic        dr;  logic [31:0] da;
      logic        lk;
      logic        fg;  logic dg;  logic [31:0] ma;
      logic        fv;  logic [31:0] fd;  logic fe;
      logic        dv;  logic [31:0] dd;  logic de;
   } vec_t;

   vec_t vt[16];

   initial begin
      // fr  fa        dr  da        lk  fg dg ma        fv fd            fe dv dd            de
      // contention right after reset: F, D, F, D
      vt[0]  = '{1, 32'h00, 1, 32'h04, 0,  1, 0, 32'h00,  0, 32'h0,          0, 0, 32'h0,          0};
      vt[1]  = '{1, 32'h00, 1, 32'h04, 0,  0, 1, 32'h04,  1, 32'hA5000000,   0, 0, 32'h0,          0};
      vt[2]  = '{1, 32'h00, 1, 32'h04, 0,  1, 0, 32'h00,  0, 32'h0,          0, 1, 32'hA5000001,   0};
      vt[3]  = '{1, 32'h00, 1, 32'h04, 0,  0, 1, 32'h04,  1, 32'hA5000000,   0, 0, 32'h0,          0};
      vt[4]  = '{0, 32'h00, 0, 32'h00, 0,  0, 0, 32'h00,  0, 32'h0,          0, 1, 32'hA5000001,   0};
      // single fetch
      vt[5]  = '{1, 32'h10, 0, 32'h00, 0,  1, 0, 32'h10,  0, 32'h0,          0, 0, 32'h0,          0};
      vt[6]  = '{0, 32'h00, 0, 32'h00, 0,  0, 0, 32'h00,  1, 32'hA5000004,   0, 0, 32'h0,          0};
      // unaligned fetch
      vt[7]  = '{1, 32'h13, 0, 32'h00, 0,  1, 0, 32'h10,  0, 32'h0,          0, 0, 32'h0,          0};
      vt[8]  = '{0, 32'h00, 0, 32'h00, 0,  0, 0, 32'h00,  1, 32'hA5000004,   0, 0, 32'h0,          0};
      // debug lock: debug wins once, then keeps the port; dropping lock hands it back
      vt[9]  = '{1, 32'h08, 1, 32'h0C, 1,  0, 1, 32'h0C,  0, 32'h0,          0, 0, 32'h0,          0};
      vt[10] = '{1, 32'h08, 1, 32'h0C, 1,  0, 1, 32'h0C,  0, 32'h0,          0, 1, 32'hA5000003,   0};
      vt[11] = '{1, 32'h08, 1, 32'h0C, 1,  0, 1, 32'h0C,  0, 32'h0,          0, 1, 32'hA5000003,   0};
      vt[12] = '{1, 32'h08, 1, 32'h0C, 0,  1, 0, 32'h08,  0, 32'h0,          0, 1, 32'hA5000003,   0};
      vt[13] = '{0, 32'h00, 0, 32'h00, 0,  0, 0, 32'h00,  1, 32'hA5000002,   0, 0, 32'h0,          0};
      // out of range debug read (index 64)
      vt[14] = '{0, 32'h00, 1, 32'h100, 0, 0, 1, 32'h100, 0, 32'h0,          0, 0, 32'h0,          0};
      vt[15] = '{0, 32'h00, 0, 32'h00, 0,  0, 0, 32'h00,  0, 32'h0,          0, 1, 32'h0,          1};
   end

   initial begin
      reset_n = 1'b0;
      model_reset();
      apply(1'b1, 32'h10, 1'b1, 32'h04, 1'b0);
      #3;
      chk("rst f_gnt",    {31'h0, f_gnt},    32'h0);
      chk("rst d_gnt",    {31'h0, d_gnt},    32'h0);
      chk("rst f_rvalid", {31'h0, f_rvalid}, 32'h0);
      chk("rst d_rvalid", {31'h0, d_rvalid}, 32'h0);
      chk("rst f_err",    {31'h0, f_err},    32'h0);
      chk("rst d_err",    {31'h0, d_err},    32'h0);
      chk("rst f_rdata",  f_rdata, 32'h0);
      chk("rst d_rdata",  d_rdata, 32'h0);
      @(posedge clk); #1;
      reset_n = 1'b1;

      // directed table
      for (int i = 0; i < 16; i++) begin
         string t;
         t = $sformatf("vec%0d", i);
         apply(vt[i].fr, vt[i].fa, vt[i].dr, vt[i].da, vt[i].lk);
         #3;
         chk({t, " f_gnt"},    {31'h0, f_gnt},    {31'h0, vt[i].fg});
         chk({t, " d_gnt"},    {31'h0, d_gnt},    {31'h0, vt[i].dg});
         chk({t, " mem_a"},    mem_a, vt[i].ma);
         chk({t, " f_rvalid"}, {31'h0, f_rvalid}, {31'h0, vt[i].fv});
         chk({t, " f_rdata"},  f_rdata, vt[i].fd);
         chk({t, " f_err"},    {31'h0, f_err},    {31'h0, vt[i].fe});
         chk({t, " d_rvalid"}, {31'h0, d_rvalid}, {31'h0, vt[i].dv});
         chk({t, " d_rdata"},  d_rdata, vt[i].dd);
         chk({t, " d_err"},    {31'h0, d_err},    {31'h0, vt[i].de});
         advance();
      end

      // reset pulsed in the cycle after a grant drops the pending response
      apply(1'b1, 32'h20, 1'b0, 32'h0, 1'b0);
      #3;
      chk("mid grant", {31'h0, f_gnt}, 32'h1);
      advance();
      chk("mid pre-rst rvalid", {31'h0, f_rvalid}, 32'h1);
      reset_n = 1'b0;
      #1;
      chk("mid in-rst rvalid", {31'h0, f_rvalid}, 32'h0);
      reset_n = 1'b1;
      model_reset();
      for (int i = 0; i < 2; i++) begin
         apply(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
         #1;
         chk("mid post f_rvalid", {31'h0, f_rvalid}, 32'h0);
         chk("mid post d_rvalid", {31'h0, d_rvalid}, 32'h0);
         advance();
      end
      apply(1'b1, 32'h00, 1'b1, 32'h04, 1'b0);
      #3;
      chk("mid contend f_gnt", {31'h0, f_gnt}, 32'h1);
      chk("mid contend d_gnt", {31'h0, d_gnt}, 32'h0);
      advance();

      // randomized traffic against the reference model
      for (int i = 0; i < 400; i++) begin
         logic        fr, dr, lk;
         logic [31:0] fa, da;
         fr = ($urandom_range(0, 3) != 0);
         dr = ($urandom_range(0, 3) != 0);
         lk = ($urandom_range(0, 2) == 0);
         fa = ($urandom_range(0, 71) << 2) | $urandom_range(0, 3);
         da = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFF0
                                           : (($urandom_range(0, 71) << 2) | $urandom_range(0, 3));
         apply(fr, fa, dr, da, lk);
         #3;
         chk_model($sformatf("rnd%0d", i));
         advance();
      end
      apply(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      #3;
      chk_model("drain");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
